// File: rtl/store_buffer_forward_unit_pkg.sv
// Shared types for the post-MEM store buffer: entry layout, drain FSM states, lane helpers.
package store_buf_pkg;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int WADDR_W   = SB_ADDR_W - 2;
  localparam logic [3:0] BYTE_EN_FULL = 4'hF;

  typedef enum logic { IDLE, WRITE } sb_state_e;

  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] waddr;
    logic [SB_DATA_W-1:0] data;
    logic [3:0]         byte_en;
  } sb_entry_t;

  function automatic logic [SB_DATA_W-1:0] merge_lanes(input logic [SB_DATA_W-1:0] old_d,
                                                       input logic [SB_DATA_W-1:0] new_d,
                                                       input logic [3:0] be);
    merge_lanes = old_d;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge_lanes[8*b +: 8] = new_d[8*b +: 8];
  endfunction
endpackage

// File: rtl/store_buffer_forward_unit_if.sv
// Stage-4 store/load lookup and data-memory write port of the store buffer.
interface store_buffer_forward_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              STORE_VALID;
  logic [ADDR_W-1:0] STORE_ADDR;
  logic [DATA_W-1:0] STORE_DATA;
  logic [3:0]        STORE_BYTE_EN;
  logic              STORE_STALL;
  logic              LOAD_VALID;
  logic [ADDR_W-1:0] LOAD_ADDR;
  logic              LOAD_FWD_HIT;
  logic [DATA_W-1:0] LOAD_FWD_DATA;
  logic              LOAD_STALL;
  logic              FLUSH_REQ;
  logic              FLUSH_DONE;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [3:0]        MEM_BYTE_EN;
  logic              MEM_BUSYWAIT;
  logic              MEM_PORT_BUSY;

  modport slave (
    input  STORE_VALID, STORE_ADDR, STORE_DATA, STORE_BYTE_EN, LOAD_VALID, LOAD_ADDR,
           FLUSH_REQ, MEM_BUSYWAIT, MEM_PORT_BUSY,
    output STORE_STALL, LOAD_FWD_HIT, LOAD_FWD_DATA, LOAD_STALL, FLUSH_DONE,
           MEM_WRITE, MEM_ADDR, MEM_WRITEDATA, MEM_BYTE_EN
  );
  modport master (
    output STORE_VALID, STORE_ADDR, STORE_DATA, STORE_BYTE_EN, LOAD_VALID, LOAD_ADDR,
           FLUSH_REQ, MEM_BUSYWAIT, MEM_PORT_BUSY,
    input  STORE_STALL, LOAD_FWD_HIT, LOAD_FWD_DATA, LOAD_STALL, FLUSH_DONE,
           MEM_WRITE, MEM_ADDR, MEM_WRITEDATA, MEM_BYTE_EN
  );
endinterface

// File: rtl/store_buffer_forward_unit_match.sv
// Youngest-match finder: scans entries from tail-1 backwards for a word-address hit.
module store_buf_match import store_buf_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] ent_i,
  input  logic [PTR_W-1:0]      tail_i,
  input  logic [WADDR_W-1:0]    waddr_i,
  output logic [PTR_W-1:0]      hit_idx_o,
  output logic                  match_o,
  output logic                  full_cover_o
);
  logic [PTR_W-1:0] idx;
  logic [DEPTH-1:0] unused_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unused
    assign unused_data[g] = ^ent_i[g].data;
  end

  // Oldest first so the youngest hit is the last one written.
  always_comb begin
    hit_idx_o = '0;
    match_o   = 1'b0;
    idx       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = tail_i - PTR_W'(i + 1);
      if (ent_i[idx].valid && ent_i[idx].waddr == waddr_i) begin
        match_o   = 1'b1;
        hit_idx_o = idx;
      end
    end
  end

  assign full_cover_o = match_o && (ent_i[hit_idx_o].byte_en == BYTE_EN_FULL);
endmodule

// File: rtl/store_buffer_forward_unit.sv
// Store buffer with store->load forwarding and a background drain FSM.
// Optional merge of pushes into the youngest entry: define STORE_BUF_COALESCE_EN.
module store_buffer_forward_unit import store_buf_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic CLK,
  input  logic RESET,
  store_buffer_forward_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] ent_q;
  logic [PTR_W-1:0]  head_q, tail_q, youngest, hit_idx;
  logic [CNT_W-1:0]  count_q;
  sb_state_e         state_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic              full, merge, alloc, pop, drain_go, hit_match, hit_full;
  logic [WADDR_W-1:0] st_waddr, ld_waddr;
  logic              unused_lsb;

  assign st_waddr   = bus.STORE_ADDR[ADDR_W-1:2];
  assign ld_waddr   = bus.LOAD_ADDR[ADDR_W-1:2];
  assign unused_lsb = ^{bus.STORE_ADDR[1:0], bus.LOAD_ADDR[1:0]};
  assign youngest   = tail_q - PTR_W'(1);
  assign full       = (count_q == CNT_W'(DEPTH));

`ifdef STORE_BUF_COALESCE_EN
  // The head being written to memory is frozen; merging into it would desync MEM_*.
  assign merge = bus.STORE_VALID && (count_q != '0) && ent_q[youngest].valid &&
                 (ent_q[youngest].waddr == st_waddr) &&
                 !(state_q == WRITE && youngest == head_q);
`else
  assign merge = 1'b0;
`endif

  assign alloc    = bus.STORE_VALID && !merge && !full;
  assign pop      = (state_q == WRITE) && mem_write_q && !bus.MEM_BUSYWAIT;
  assign drain_go = (state_q == IDLE) && (count_q != '0) &&
                    (!bus.MEM_PORT_BUSY || bus.FLUSH_REQ);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ent_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      if (alloc) begin
        ent_q[tail_q] <= '{valid: 1'b1, waddr: st_waddr, data: bus.STORE_DATA,
                           byte_en: bus.STORE_BYTE_EN};
        tail_q <= tail_q + PTR_W'(1);
      end
`ifdef STORE_BUF_COALESCE_EN
      if (merge) begin
        ent_q[youngest].data    <= merge_lanes(ent_q[youngest].data, bus.STORE_DATA, bus.STORE_BYTE_EN);
        ent_q[youngest].byte_en <= ent_q[youngest].byte_en | bus.STORE_BYTE_EN;
      end
`endif
      if (pop) begin
        ent_q[head_q].valid <= 1'b0;
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);

      case (state_q)
        IDLE: if (drain_go) begin
          state_q     <= WRITE;
          mem_write_q <= 1'b1;
          mem_addr_q  <= {ent_q[head_q].waddr, 2'b00};
          mem_wdata_q <= ent_q[head_q].data;
          mem_be_q    <= ent_q[head_q].byte_en;
        end
        WRITE: if (pop) begin
          state_q     <= IDLE;
          mem_write_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  store_buf_match #(.DEPTH(DEPTH)) u_match (
    .ent_i       (ent_q),
    .tail_i      (tail_q),
    .waddr_i     (ld_waddr),
    .hit_idx_o   (hit_idx),
    .match_o     (hit_match),
    .full_cover_o(hit_full)
  );

  assign bus.STORE_STALL   = full && !merge;
  assign bus.LOAD_FWD_HIT  = bus.LOAD_VALID && hit_match && hit_full;
  assign bus.LOAD_STALL    = bus.LOAD_VALID && hit_match && !hit_full;
  assign bus.LOAD_FWD_DATA = bus.LOAD_FWD_HIT ? ent_q[hit_idx].data : '0;
  assign bus.FLUSH_DONE    = (count_q == '0) && (state_q == IDLE);
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDR      = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.MEM_BYTE_EN   = mem_be_q;
endmodule

// File: tb/tb_store_buffer_forward_unit.sv
// Directed bench for the store buffer: drain timing, full stall, forwarding, flush, reset.
module tb_store_buffer_forward_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n;
  logic [67:0] wr_q[$];

  always #5 clk = ~clk;

  store_buffer_forward_unit_if bus ();

  store_buffer_forward_unit dut (.CLK(clk), .RESET(rst), .bus(bus));

  // memory-side log of accepted writes: {addr, data, byte_en}
  always @(posedge clk)
    if (!rst && bus.MEM_WRITE && !bus.MEM_BUSYWAIT)
      wr_q.push_back({bus.MEM_ADDR, bus.MEM_WRITEDATA, bus.MEM_BYTE_EN});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.STORE_VALID = 1'b1; bus.STORE_ADDR = a; bus.STORE_DATA = d; bus.STORE_BYTE_EN = be;
    tick();
    bus.STORE_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!bus.FLUSH_DONE && k < 100) begin tick(); k++; end
    chk(tag, 32'(bus.FLUSH_DONE), 32'd1);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    logic [67:0] e;
    e = (i < wr_q.size()) ? wr_q[i] : '0;
    chk({tag, "_addr"}, e[67:36], a);
    chk({tag, "_data"}, e[35:4], d);
    chk({tag, "_be"}, 32'(e[3:0]), 32'(be));
  endtask

  initial begin
    bus.STORE_VALID = 0; bus.STORE_ADDR = 0; bus.STORE_DATA = 0; bus.STORE_BYTE_EN = 0;
    bus.LOAD_VALID = 0; bus.LOAD_ADDR = 0; bus.FLUSH_REQ = 0;
    bus.MEM_BUSYWAIT = 0; bus.MEM_PORT_BUSY = 0;
    tick(); tick();
    chk("rst_memwr", 32'(bus.MEM_WRITE), 0);
    chk("rst_sstall", 32'(bus.STORE_STALL), 0);
    chk("rst_hit", 32'(bus.LOAD_FWD_HIT), 0);
    chk("rst_lstall", 32'(bus.LOAD_STALL), 0);
    chk("rst_fdone", 32'(bus.FLUSH_DONE), 1);
    chk("rst_maddr", bus.MEM_ADDR, 0);
    chk("rst_mdata", bus.MEM_WRITEDATA, 0);
    rst = 1'b0;

    // single SW: write visible two cycles after the store, for one cycle
    store(32'h100, 32'hDEADBEEF, 4'hF);
    chk("sw_wr_early", 32'(bus.MEM_WRITE), 0);
    tick();
    chk("sw_wr", 32'(bus.MEM_WRITE), 1);
    chk("sw_addr", bus.MEM_ADDR, 32'h100);
    chk("sw_data", bus.MEM_WRITEDATA, 32'hDEADBEEF);
    chk("sw_be", 32'(bus.MEM_BYTE_EN), 32'hF);
    chk("sw_fdone_busy", 32'(bus.FLUSH_DONE), 0);
    tick();
    chk("sw_wr_off", 32'(bus.MEM_WRITE), 0);
    chk("sw_fdone", 32'(bus.FLUSH_DONE), 1);
    chk("sw_nwr", wr_q.size(), 1);

    // fill to full under busywait, hold a fifth store, then drain in order
    wr_q.delete();
    bus.MEM_BUSYWAIT = 1;
    store(32'h10, 32'hA0, 4'hF);
    store(32'h14, 32'hA1, 4'hF);
    store(32'h18, 32'hA2, 4'hF);
    chk("fill_nostall3", 32'(bus.STORE_STALL), 0);
    store(32'h1C, 32'hA3, 4'hF);
    chk("fill_stall", 32'(bus.STORE_STALL), 1);
    bus.STORE_VALID = 1; bus.STORE_ADDR = 32'h20; bus.STORE_DATA = 32'hA4; bus.STORE_BYTE_EN = 4'hF;
    tick(); tick();
    chk("fill_held", 32'(bus.STORE_STALL), 1);
    chk("fill_hold_wr", 32'(bus.MEM_WRITE), 1);
    chk("fill_hold_addr", bus.MEM_ADDR, 32'h10);
    chk("fill_none", wr_q.size(), 0);
    bus.MEM_BUSYWAIT = 0;
    n = 0;
    while (bus.STORE_STALL && n < 20) begin tick(); n++; end
    chk("fill_unstall", 32'(n < 20), 1);
    tick();
    bus.STORE_VALID = 0;
    wait_idle("fill_drain");
    chk("fill_nwr", wr_q.size(), 5);
    chk_wr("fill0", 0, 32'h10, 32'hA0, 4'hF);
    chk_wr("fill1", 1, 32'h14, 32'hA1, 4'hF);
    chk_wr("fill3", 3, 32'h1C, 32'hA3, 4'hF);
    chk_wr("fill4", 4, 32'h20, 32'hA4, 4'hF);

    // forwarding: full-word hit, youngest wins, same-cycle push invisible
    wr_q.delete();
    bus.MEM_BUSYWAIT = 1;
    store(32'h200, 32'h11223344, 4'hF);
    bus.LOAD_VALID = 1; bus.LOAD_ADDR = 32'h200;
    #1;
    chk("fwd_hit", 32'(bus.LOAD_FWD_HIT), 1);
    chk("fwd_data", bus.LOAD_FWD_DATA, 32'h11223344);
    chk("fwd_nostall", 32'(bus.LOAD_STALL), 0);
    store(32'h200, 32'h55667788, 4'hF);
    chk("fwd_young", bus.LOAD_FWD_DATA, 32'h55667788);
    bus.STORE_VALID = 1; bus.STORE_ADDR = 32'h200; bus.STORE_DATA = 32'h99AABBCC; bus.STORE_BYTE_EN = 4'hF;
    #1;
    chk("fwd_samecyc", bus.LOAD_FWD_DATA, 32'h55667788);
    tick();
    bus.STORE_VALID = 0;
    chk("fwd_young2", bus.LOAD_FWD_DATA, 32'h99AABBCC);
    bus.LOAD_ADDR = 32'h204;
    #1;
    chk("fwd_miss_hit", 32'(bus.LOAD_FWD_HIT), 0);
    chk("fwd_miss_data", bus.LOAD_FWD_DATA, 0);
    bus.LOAD_ADDR = 32'h200; bus.LOAD_VALID = 0;
    #1;
    chk("fwd_noload", 32'(bus.LOAD_FWD_HIT), 0);
    bus.MEM_BUSYWAIT = 0;
    wait_idle("fwd_drain");
    chk("fwd_nwr", wr_q.size(), 3);

    // partial-lane match stalls the load until the write retires
    wr_q.delete();
    bus.MEM_BUSYWAIT = 1;
    store(32'h300, 32'h000000AA, 4'b0001);
    bus.LOAD_VALID = 1; bus.LOAD_ADDR = 32'h300;
    #1;
    chk("sb_stall", 32'(bus.LOAD_STALL), 1);
    chk("sb_nohit", 32'(bus.LOAD_FWD_HIT), 0);
    chk("sb_data0", bus.LOAD_FWD_DATA, 0);
    tick(); tick();
    chk("sb_inwrite", 32'(bus.MEM_WRITE), 1);
    chk("sb_stall_drain", 32'(bus.LOAD_STALL), 1);
    bus.MEM_BUSYWAIT = 0;
    n = 0;
    while (bus.LOAD_STALL && n < 20) begin tick(); n++; end
    chk("sb_release", 32'(n < 20), 1);
    bus.LOAD_VALID = 0;
    wait_idle("sb_drain");
    chk_wr("sb", 0, 32'h300, 32'h000000AA, 4'b0001);

    // port busy blocks draining until a flush overrides it
    wr_q.delete();
    bus.MEM_PORT_BUSY = 1;
    store(32'h500, 32'hB0, 4'hF);
    store(32'h504, 32'hB1, 4'hF);
    tick(); tick();
    chk("pb_nowr", 32'(bus.MEM_WRITE), 0);
    chk("pb_nodone", 32'(bus.FLUSH_DONE), 0);
    bus.FLUSH_REQ = 1;
    wait_idle("pb_flush");
    bus.FLUSH_REQ = 0; bus.MEM_PORT_BUSY = 0;
    chk("pb_nwr", wr_q.size(), 2);
    chk_wr("pb0", 0, 32'h500, 32'hB0, 4'hF);
    chk_wr("pb1", 1, 32'h504, 32'hB1, 4'hF);

    // reset in the middle of a write drops everything
    wr_q.delete();
    bus.MEM_BUSYWAIT = 1;
    store(32'h600, 32'hC0, 4'hF);
    store(32'h604, 32'hC1, 4'hF);
    store(32'h608, 32'hC2, 4'hF);
    chk("mr_inwrite", 32'(bus.MEM_WRITE), 1);
    rst = 1;
    tick();
    bus.LOAD_VALID = 1; bus.LOAD_ADDR = 32'h600;
    #1;
    chk("mr_wr", 32'(bus.MEM_WRITE), 0);
    chk("mr_done", 32'(bus.FLUSH_DONE), 1);
    chk("mr_hit", 32'(bus.LOAD_FWD_HIT), 0);
    chk("mr_addr", bus.MEM_ADDR, 0);
    rst = 0; bus.LOAD_VALID = 0; bus.MEM_BUSYWAIT = 0;
    tick(); tick(); tick();
    chk("mr_nowr", wr_q.size(), 0);

    // two byte stores to one word: merged when coalescing is built
    wr_q.delete();
    bus.MEM_PORT_BUSY = 1;
    store(32'h400, 32'h000000AA, 4'b0001);
    store(32'h400, 32'h0000BB00, 4'b0010);
    bus.MEM_PORT_BUSY = 0;
    wait_idle("co_drain");
`ifdef STORE_BUF_COALESCE_EN
    chk("co_nwr", wr_q.size(), 1);
    chk_wr("co", 0, 32'h400, 32'h0000BBAA, 4'b0011);
`else
    chk("co_nwr", wr_q.size(), 2);
    chk_wr("co0", 0, 32'h400, 32'h000000AA, 4'b0001);
    chk_wr("co1", 1, 32'h400, 32'h0000BB00, 4'b0010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer_forward_unit.md
Name: store_buffer_forward_unit

Overview:
- Post-MEM store buffer for the RV32IM pipeline. Committed stores are queued in a small FIFO and drained to data memory in the background.
- A younger load that hits a buffered store gets its data forwarded from the buffer, so the buffer is the store→load forwarding path.
- Sits between the stage-4 memory interface and data memory. The load-data mux and the hazard unit consume its hit/stall outputs.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, ≥2).
- ADDR_W, 32, byte address width; entries store word address ADDR_W-2 bits.
- DATA_W, 32, data width (fixed 32 for RV32).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous active-high reset.
- STORE_VALID  input  1  stage-4 store commits this cycle.
- STORE_ADDR  input  ADDR_W  store byte address (bits[1:0] ignored; byte lanes given by STORE_BYTE_EN).
- STORE_DATA  input  DATA_W  store data, already lane-aligned.
- STORE_BYTE_EN  input  4  byte lane enables (SB/SH/SW).
- STORE_STALL  output  1  buffer full, stage 4 must hold the store.
- LOAD_VALID  input  1  stage-4 load lookup.
- LOAD_ADDR  input  ADDR_W  load byte address.
- LOAD_FWD_HIT  output  1  forward LOAD_FWD_DATA instead of memory data.
- LOAD_FWD_DATA  output  DATA_W  full word from youngest matching entry.
- LOAD_STALL  output  1  partial-lane match, load must wait for drain.
- FLUSH_REQ  input  1  fence/ecall: drain everything.
- FLUSH_DONE  output  1  buffer empty and no write in flight.
- MEM_WRITE  output  1  data-memory write request.
- MEM_ADDR  output  ADDR_W  word-aligned write address ({waddr,2'b00}).
- MEM_WRITEDATA  output  DATA_W  write data.
- MEM_BYTE_EN  output  4  write lane enables.
- MEM_BUSYWAIT  input  1  memory busy; request held while high.
- MEM_PORT_BUSY  input  1  a memory read owns the port this cycle; no new write is launched.

Behaviour:
- Reset (synchronous): head, tail and count cleared; all entry valids cleared; FSM→IDLE. On the next cycle MEM_WRITE=0, STORE_STALL=0, LOAD_FWD_HIT=0, LOAD_STALL=0, FLUSH_DONE=1, and MEM_* data/addr/byte-en are 0. A reset during WRITE aborts the write; loss of queued stores is accepted.
- Storage: circular FIFO of DEPTH entries {valid, waddr, data, byte_en}, plus head, tail and count (clog2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Push: STORE_VALID && !STORE_STALL writes the entry at tail at the clock edge.
- STORE_STALL = (count==DEPTH), from registered count only. A pop in the same cycle does not unblock a push; the push lands the next cycle.
- Drain FSM:
  - IDLE: if count>0 && !MEM_PORT_BUSY, go to WRITE. MEM_* is driven registered from the head entry; MEM_WRITE=1 starting the cycle after the decision.
  - WRITE: hold MEM_WRITE and all MEM_* stable while MEM_BUSYWAIT=1. On the first cycle MEM_WRITE=1 && MEM_BUSYWAIT=0, pop the head (head++, count--, valid cleared), deassert MEM_WRITE next cycle, and return to IDLE.
  - Throughput is at most one store per 2 cycles.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Load lookup (combinational, same cycle):
  - Compare LOAD_ADDR[ADDR_W-1:2] against all valid entries; the entry being drained still counts as valid.
  - Youngest match selected by age from tail-1 backwards.
  - LOAD_FWD_HIT=1 if the youngest match has byte_en==4'hF; LOAD_FWD_DATA = that entry's data, else 0.
  - LOAD_STALL=1 if the youngest match has partial byte_en.
  - A store pushed in the same cycle is not visible to the lookup. The hazard unit guarantees a one-cycle separation.
  - With LOAD_VALID=0, both hit and stall are 0.
- Flush: FLUSH_REQ only suppresses the MEM_PORT_BUSY gate (drains with priority). FLUSH_DONE = (count==0) && state==IDLE.
- Invariants:
  - Stores reach memory in program order, one write per entry.
  - An entry is never popped while MEM_BUSYWAIT=1.

Optional Feature:
- STORE_BUF_COALESCE_EN defined: a push whose word address matches the youngest valid entry merges into it, provided that entry is not the head currently in WRITE.
  - Merge is lane-wise: data lanes overwritten where STORE_BYTE_EN is set, byte_en |= STORE_BYTE_EN.
  - count is unchanged, so the merge is allowed even when full, and STORE_STALL is suppressed for that push.
- Undefined: every push allocates a new entry; no merge logic is built.

Decomposition:
- Package store_buf_pkg: entry struct {valid, waddr, data, byte_en}, FSM state enum {IDLE, WRITE}, BYTE_EN_FULL=4'hF.
- One sub-module, store_buf_match: combinational youngest-match finder. Inputs: entries, tail, load waddr. Outputs: hit index, match, full_cover.

Test Plan:
- Reset, then SW 0x100←0xDEADBEEF with MEM_BUSYWAIT=0 → MEM_WRITE=1 for one cycle two cycles later with MEM_ADDR=0x100, MEM_BYTE_EN=F; FLUSH_DONE returns to 1.
- Push 4 SWs (0x10, 0x14, 0x18, 0x1C) while MEM_BUSYWAIT=1 → STORE_STALL=1 after the 4th; a 5th store is held; memory sees all 4 in order after busywait drops.
- SW 0x200←0x11223344 then LW 0x200 before drain → LOAD_FWD_HIT=1, LOAD_FWD_DATA=0x11223344; two SWs to 0x200 → youngest data forwarded.
- SB 0x300 (byte_en 4'b0001) then LW 0x300 → LOAD_STALL=1 until the write completes, then 0.
- MEM_PORT_BUSY=1 with count=2 → no MEM_WRITE; assert FLUSH_REQ → drain starts, FLUSH_DONE=1 after both writes.
- RESET asserted mid-WRITE with count=3 → next cycle MEM_WRITE=0, count=0, LOAD_FWD_HIT=0. With coalesce enabled: SB 0x400 lane0 then SB 0x400 lane1 → single entry, byte_en=4'b0011, one memory write.
